// File: rtl/ad_ip_jesd204_tpl_dac_channel_gen2_pkg.sv
// Shared constants for the gen2 TPL DAC channel: source-select codes,
// underflow counter width and pipeline latency.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam logic [3:0] SEL_DDS   = 4'd0;
    localparam logic [3:0] SEL_PAT   = 4'd1;
    localparam logic [3:0] SEL_DMA   = 4'd2;
    localparam logic [3:0] SEL_ZERO  = 4'd3;
    localparam logic [3:0] SEL_NPN7  = 4'd4;
    localparam logic [3:0] SEL_NPN15 = 4'd5;
    localparam logic [3:0] SEL_PN7   = 4'd6;
    localparam logic [3:0] SEL_PN15  = 4'd7;
    localparam logic [3:0] SEL_RAMP  = 4'd8;

    localparam int unsigned UFL_CNT_WIDTH = 16;
    localparam int unsigned PIPE_LATENCY  = 2;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_channel_gen2_if.sv
// DMA beat handshake for the gen2 TPL DAC channel (16-bit sample slots).
interface ad_ip_jesd204_tpl_dac_channel_gen2_if #(
    parameter int unsigned DATA_PATH_WIDTH = 4
);
    logic [16*DATA_PATH_WIDTH-1:0] dma_data;
    logic                          dma_valid;
    logic                          dma_ready;

    modport master (output dma_data, output dma_valid, input dma_ready);
    modport slave  (input dma_data, input dma_valid, output dma_ready);
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_pat_mem.sv
// Simple dual-port pattern RAM, one synchronous read-first read port.
module ad_ip_jesd204_tpl_dac_pat_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Non-blocking read of the same address returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_channel_gen2.sv
// Per-converter DAC source selector with a fixed 2-cycle latency.
// Optional underflow counter enabled by AD_TPL_DAC_UNDERFLOW_CNT_EN.
module ad_ip_jesd204_tpl_dac_channel_gen2
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned DATA_PATH_WIDTH      = 4,
    parameter int unsigned CONVERTER_RESOLUTION = 16,
    parameter int unsigned PAT_DEPTH            = 16,
    parameter int unsigned SYNC_SEL_SWITCH      = 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    ad_ip_jesd204_tpl_dac_channel_gen2_if.slave              dma,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  dds_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  pn7_data,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  pn15_data,
    input  logic                                             dac_data_sync,
    input  logic [3:0]                                       dac_data_sel,
    input  logic                                             pat_wr_en,
    input  logic [$clog2(PAT_DEPTH)-1:0]                     pat_wr_addr,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  pat_wr_data,
    input  logic [$clog2(PAT_DEPTH)-1:0]                     pat_last,
    input  logic [CONVERTER_RESOLUTION-1:0]                  ramp_step,
    input  logic                                             dac_underflow_hold,
    input  logic                                             underflow_clr,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  dac_data,
    output logic                                             dac_enable,
    output logic [3:0]                                       dac_sel_active,
    output logic                                             dac_underflow,
    output logic [UFL_CNT_WIDTH-1:0]                         dac_underflow_cnt
);
    localparam int unsigned CR = CONVERTER_RESOLUTION;
    localparam int unsigned DW = DATA_PATH_WIDTH * CR;
    localparam int unsigned AW = $clog2(PAT_DEPTH);

    logic [3:0]    sel_active;
    logic [3:0]    sel_d1;
    logic [AW-1:0] pat_ptr;
    logic [CR-1:0] ramp_acc;
    logic [DW-1:0] dds_q, pn7_q, pn15_q, ramp_q, dma_q, pat_q;
    logic [DW-1:0] dma_last, ramp_beat, dma_beat, mux_data;
    logic          sel_load;
    logic          underflow;

    assign sel_load       = (SYNC_SEL_SWITCH != 0) ? dac_data_sync : 1'b1;
    assign dma.dma_ready  = (sel_active == SEL_DMA);
    assign underflow      = dma.dma_ready & ~dma.dma_valid;
    assign dac_underflow  = underflow;
    assign dac_sel_active = sel_active;

    always_comb begin
        ramp_beat = '0;
        dma_beat  = '0;
        for (int unsigned i = 0; i < DATA_PATH_WIDTH; i++) begin
            ramp_beat[i*CR +: CR] = ramp_acc + CR'(i) * ramp_step;
            dma_beat[i*CR +: CR]  = dma.dma_data[16*i +: CR];
        end
    end

    ad_ip_jesd204_tpl_dac_pat_mem #(
        .DEPTH (PAT_DEPTH),
        .WIDTH (DW)
    ) i_pat_mem (
        .clk     (clk),
        .wr_en   (pat_wr_en),
        .wr_addr (pat_wr_addr),
        .wr_data (pat_wr_data),
        .rd_addr (pat_ptr),
        .rd_data (pat_q)
    );

    // Stage 1: source beats, playback pointers and select alignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_active <= SEL_ZERO;
            sel_d1     <= SEL_ZERO;
            pat_ptr    <= '0;
            ramp_acc   <= '0;
            dds_q      <= '0;
            pn7_q      <= '0;
            pn15_q     <= '0;
            ramp_q     <= '0;
            dma_q      <= '0;
            dma_last   <= '0;
        end else begin
            if (sel_load) begin
                sel_active <= dac_data_sel;
            end
            sel_d1 <= sel_active;

            if (dac_data_sync) begin
                pat_ptr <= '0;
            end else if (sel_active == SEL_PAT) begin
                pat_ptr <= (pat_ptr >= pat_last) ? '0 : pat_ptr + 1'b1;
            end

            if (dac_data_sync) begin
                ramp_acc <= '0;
            end else if (sel_active == SEL_RAMP) begin
                ramp_acc <= ramp_acc + CR'(DATA_PATH_WIDTH) * ramp_step;
            end

            dds_q  <= dds_data;
            pn7_q  <= pn7_data;
            pn15_q <= pn15_data;
            ramp_q <= ramp_beat;

            if (dma.dma_ready && dma.dma_valid) begin
                dma_last <= dma_beat;
                dma_q    <= dma_beat;
            end else if (underflow && dac_underflow_hold) begin
                dma_q <= dma_last;
            end else begin
                dma_q <= '0;
            end
        end
    end

    always_comb begin
        mux_data = dds_q;
        case (sel_d1)
            SEL_PAT:   mux_data = pat_q;
            SEL_DMA:   mux_data = dma_q;
            SEL_ZERO:  mux_data = '0;
            SEL_NPN7:  mux_data = ~pn7_q;
            SEL_NPN15: mux_data = ~pn15_q;
            SEL_PN7:   mux_data = pn7_q;
            SEL_PN15:  mux_data = pn15_q;
            SEL_RAMP:  mux_data = ramp_q;
            default:   mux_data = dds_q;
        endcase
    end

    // Stage 2: output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data   <= '0;
            dac_enable <= 1'b0;
        end else begin
            dac_data   <= mux_data;
            dac_enable <= (sel_d1 == SEL_DMA);
        end
    end

`ifdef AD_TPL_DAC_UNDERFLOW_CNT_EN
    logic [UFL_CNT_WIDTH-1:0] ufl_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ufl_cnt <= '0;
        end else if (underflow_clr) begin
            ufl_cnt <= '0;
        end else if (underflow && (ufl_cnt != '1)) begin
            ufl_cnt <= ufl_cnt + 1'b1;
        end
    end

    assign dac_underflow_cnt = ufl_cnt;
`else
    logic unused_underflow_clr;
    assign unused_underflow_clr = underflow_clr;
    assign dac_underflow_cnt    = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_gen2.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_channel_gen2 against a
// source-level behavioural model with a 2-beat output delay queue.
module tb_ad_ip_jesd204_tpl_dac_channel_gen2;
    localparam int unsigned DPW = 4;
    localparam int unsigned CR  = 16;
    localparam int unsigned DW  = DPW * CR;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_channel_gen2_if #(.DATA_PATH_WIDTH(DPW)) dma_if ();

    logic [DW-1:0] dds_data = '0, pn7_data = '0, pn15_data = '0, pat_wr_data = '0;
    logic          dac_data_sync = 1'b0, pat_wr_en = 1'b0;
    logic [3:0]    dac_data_sel = 4'd3, pat_wr_addr = '0, pat_last = '0;
    logic [CR-1:0] ramp_step = '0;
    logic          dac_underflow_hold = 1'b0, underflow_clr = 1'b0;
    logic [DW-1:0] dac_data;
    logic          dac_enable, dac_underflow;
    logic [3:0]    dac_sel_active;
    logic [15:0]   dac_underflow_cnt;

    ad_ip_jesd204_tpl_dac_channel_gen2 #(
        .DATA_PATH_WIDTH      (DPW),
        .CONVERTER_RESOLUTION (CR),
        .PAT_DEPTH            (16),
        .SYNC_SEL_SWITCH      (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dma                (dma_if),
        .dds_data           (dds_data),
        .pn7_data           (pn7_data),
        .pn15_data          (pn15_data),
        .dac_data_sync      (dac_data_sync),
        .dac_data_sel       (dac_data_sel),
        .pat_wr_en          (pat_wr_en),
        .pat_wr_addr        (pat_wr_addr),
        .pat_wr_data        (pat_wr_data),
        .pat_last           (pat_last),
        .ramp_step          (ramp_step),
        .dac_underflow_hold (dac_underflow_hold),
        .underflow_clr      (underflow_clr),
        .dac_data           (dac_data),
        .dac_enable         (dac_enable),
        .dac_sel_active     (dac_sel_active),
        .dac_underflow      (dac_underflow),
        .dac_underflow_cnt  (dac_underflow_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0]    m_sel = 4'd3;
    int unsigned   m_ptr = 0;
    logic [15:0]   m_acc = '0;
    logic [DW-1:0] m_last = '0;
    int unsigned   m_cnt = 0;
    logic [DW-1:0] m_mem [16];
    logic [DW:0]   m_q [$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_en = 1'b0;

    function automatic logic [DW-1:0] lanes4(input logic [15:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [DW-1:0] model_beat();
        logic [DW-1:0] b;
        b = '0;
        case (m_sel)
            4'd1: b = m_mem[m_ptr];
            4'd2: b = dma_if.dma_valid ? dma_if.dma_data : (dac_underflow_hold ? m_last : '0);
            4'd3: b = '0;
            4'd4: b = ~pn7_data;
            4'd5: b = ~pn15_data;
            4'd6: b = pn7_data;
            4'd7: b = pn15_data;
            4'd8: for (int i = 0; i < DPW; i++) b[i*CR +: CR] = m_acc + i * ramp_step;
            default: b = dds_data;
        endcase
        return b;
    endfunction

    // One clock: model computes this cycle's beat, then applies edge effects.
    task automatic tick();
        logic [DW-1:0] b;
        logic ufl;
        b = model_beat();
        ufl = (m_sel == 4'd2) && !dma_if.dma_valid;
        m_q.push_back({m_sel == 4'd2, b});
        @(posedge clk);
        if (reset) begin
            m_sel = 4'd3; m_ptr = 0; m_acc = '0; m_last = '0; m_cnt = 0;
            m_q.delete();
            m_q.push_back('0);
            exp_data = '0; exp_en = 1'b0;
        end else begin
            if (pat_wr_en) m_mem[pat_wr_addr] = pat_wr_data;
            if (dac_data_sync) m_ptr = 0;
            else if (m_sel == 4'd1) m_ptr = (m_ptr >= pat_last) ? 0 : m_ptr + 1;
            if (dac_data_sync) m_acc = '0;
            else if (m_sel == 4'd8) m_acc = m_acc + 4 * ramp_step;
            if (m_sel == 4'd2 && dma_if.dma_valid) m_last = dma_if.dma_data;
`ifdef AD_TPL_DAC_UNDERFLOW_CNT_EN
            if (underflow_clr) m_cnt = 0;
            else if (ufl) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
`endif
            if (dac_data_sync) m_sel = dac_data_sel;
            {exp_en, exp_data} = m_q.pop_front();
        end
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        dds_data = {$urandom, $urandom};
        pn7_data = {$urandom, $urandom};
        pn15_data = {$urandom, $urandom};
        dma_if.dma_data = {$urandom, $urandom};
        dma_if.dma_valid = ($urandom_range(0, 3) != 0);
        dac_underflow_hold = $urandom_range(0, 1);
        ramp_step = 16'($urandom);
        pat_wr_en = $urandom_range(0, 1);
        pat_wr_addr = 4'($urandom);
        pat_wr_data = {$urandom, $urandom};
        underflow_clr = ($urandom_range(0, 15) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (dac_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", dac_data); end
        checks++; if (dac_enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%b exp=0", dac_enable); end
        checks++; if (dac_sel_active !== 4'd3) begin failures++; $display("FAIL rst_sel got=%h exp=3", dac_sel_active); end
        checks++; if (dac_underflow !== 1'b0) begin failures++; $display("FAIL rst_ufl got=%b exp=0", dac_underflow); end
        checks++; if (dac_underflow_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", dac_underflow_cnt); end
        checks++; if (dma_if.dma_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", dma_if.dma_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pattern();
        logic [DW-1:0] want;
        for (int n = 0; n < 16; n++) begin
            pat_wr_en = 1'b1;
            pat_wr_addr = 4'(n);
            pat_wr_data = (n < 4) ? lanes4(16'h1000 + 16'(n), 16'h1000 + 16'(n), 16'h1000 + 16'(n), 16'h1000 + 16'(n))
                                  : {$urandom, $urandom};
            tick();
        end
        pat_wr_en = 1'b0;
        pat_last = 4'd3;
        dac_data_sel = 4'd1;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k >= 2) begin
                want = lanes4(16'h1000 + 16'((k-2)%4), 16'h1000 + 16'((k-2)%4), 16'h1000 + 16'((k-2)%4), 16'h1000 + 16'((k-2)%4));
                checks++; if (dac_data !== want) begin failures++; $display("FAIL pat_seq k=%0d got=%h exp=%h", k, dac_data, want); end
            end else begin
                checks++; if (dac_data !== '0) begin failures++; $display("FAIL pat_pre k=%0d got=%h exp=0", k, dac_data); end
            end
        end
        // random writes during playback, changing loop length
        for (int n = 0; n < 60; n++) begin
            pat_wr_en = $urandom_range(0, 1);
            pat_wr_addr = ($urandom_range(0, 1) == 0) ? 4'(m_ptr) : 4'($urandom);
            pat_wr_data = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) pat_last = 4'($urandom);
            dac_data_sync = ($urandom_range(0, 15) == 0);
            tick();
            checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL pat_rand n=%0d got=%h exp=%h", n, dac_data, exp_data); end
        end
        pat_wr_en = 1'b0;
        dac_data_sync = 1'b0;
    endtask

    task automatic test_ramp();
        logic [DW-1:0] want;
        dac_data_sel = 4'd8;
        ramp_step = 16'd1;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                for (int i = 0; i < DPW; i++) want[i*CR +: CR] = 16'(4*(k-2) + i);
                checks++; if (dac_data !== want) begin failures++; $display("FAIL ramp_seq k=%0d got=%h exp=%h", k, dac_data, want); end
            end
        end
        ramp_step = (16'hFFFC - m_acc) / 4;
        tick();
        ramp_step = 16'd1;
        tick();
        checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL ramp_jump got=%h exp=%h", dac_data, exp_data); end
        tick();
        checks++; if (dac_data !== 64'hFFFF_FFFE_FFFD_FFFC) begin failures++; $display("FAIL ramp_top got=%h exp=fffffffefffdfffc", dac_data); end
        tick();
        checks++; if (dac_data !== 64'h0003_0002_0001_0000) begin failures++; $display("FAIL ramp_wrap got=%h exp=0003000200010000", dac_data); end
        for (int n = 0; n < 30; n++) begin
            ramp_step = 16'($urandom);
            dac_data_sync = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL ramp_rand n=%0d got=%h exp=%h", n, dac_data, exp_data); end
        end
        dac_data_sync = 1'b0;
    endtask

    task automatic test_dma_underflow();
        logic [DW-1:0] v;
        logic [DW-1:0] want;
        int unsigned   want_cnt;
        underflow_clr = 1'b1;
        dac_data_sel = 4'd2;
        dac_data_sync = 1'b1;
        dma_if.dma_valid = 1'b1;
        tick();
        underflow_clr = 1'b0;
        dac_data_sync = 1'b0;
        for (int r = 0; r < 2; r++) begin
            dac_underflow_hold = (r == 0);
            v = (r == 0) ? lanes4(16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD) : lanes4(16'h1234, 16'h1234, 16'h1234, 16'h1234);
            for (int j = 0; j < 6; j++) begin
                dma_if.dma_valid = !(j >= 1 && j <= 3);
                dma_if.dma_data = (j == 0) ? v : {$urandom, $urandom};
                #1;
                checks++; if (dma_if.dma_ready !== 1'b1) begin failures++; $display("FAIL dma_ready r=%0d j=%0d got=%b exp=1", r, j, dma_if.dma_ready); end
                checks++; if (dac_underflow !== (j >= 1 && j <= 3)) begin failures++; $display("FAIL dma_ufl r=%0d j=%0d got=%b", r, j, dac_underflow); end
                tick();
                checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL dma_model r=%0d j=%0d got=%h exp=%h", r, j, dac_data, exp_data); end
                if (j >= 1 && j <= 4) begin
                    want = (j == 1 || r == 0) ? v : '0;
                    checks++; if (dac_data !== want) begin failures++; $display("FAIL dma_hold r=%0d j=%0d got=%h exp=%h", r, j, dac_data, want); end
                end
                if (r == 0 && j <= 1) begin
                    checks++; if (dac_enable !== (j == 1)) begin failures++; $display("FAIL dma_en j=%0d got=%b exp=%b", j, dac_enable, j == 1); end
                end
                if (j == 3) begin
`ifdef AD_TPL_DAC_UNDERFLOW_CNT_EN
                    want_cnt = 3 * (r + 1);
`else
                    want_cnt = 0;
`endif
                    checks++; if (dac_underflow_cnt !== 16'(want_cnt)) begin failures++; $display("FAIL dma_cnt r=%0d got=%0d exp=%0d", r, dac_underflow_cnt, want_cnt); end
                end
            end
        end
        for (int n = 0; n < 60; n++) begin
            randomize_inputs();
            pat_wr_en = 1'b0;
            #1;
            checks++; if (dac_underflow !== !dma_if.dma_valid) begin failures++; $display("FAIL dma_rand_ufl n=%0d got=%b", n, dac_underflow); end
            tick();
            checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL dma_rand n=%0d got=%h exp=%h", n, dac_data, exp_data); end
            checks++; if (dac_underflow_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL dma_rand_cnt n=%0d got=%0d exp=%0d", n, dac_underflow_cnt, m_cnt); end
        end
        underflow_clr = 1'b0;
    endtask

    task automatic test_sync_switch();
        dma_if.dma_valid = 1'b1;
        dac_data_sel = 4'd3;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        tick(); tick();
        dac_data_sel = 4'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (dac_sel_active !== 4'd3) begin failures++; $display("FAIL sw_hold_sel k=%0d got=%h exp=3", k, dac_sel_active); end
            checks++; if (dma_if.dma_ready !== 1'b0) begin failures++; $display("FAIL sw_hold_ready k=%0d got=%b exp=0", k, dma_if.dma_ready); end
        end
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        checks++; if (dac_sel_active !== 4'd2) begin failures++; $display("FAIL sw_sel got=%h exp=2", dac_sel_active); end
        checks++; if (dma_if.dma_ready !== 1'b1) begin failures++; $display("FAIL sw_ready got=%b exp=1", dma_if.dma_ready); end
        tick();
        checks++; if (dac_enable !== 1'b0) begin failures++; $display("FAIL sw_en1 got=%b exp=0", dac_enable); end
        tick();
        checks++; if (dac_enable !== 1'b1) begin failures++; $display("FAIL sw_en2 got=%b exp=1", dac_enable); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 250; n++) begin
            randomize_inputs();
            dac_data_sel = 4'($urandom);
            dac_data_sync = ($urandom_range(0, 2) == 0);
            pat_last = 4'($urandom);
            #1;
            checks++; if (dma_if.dma_ready !== (m_sel == 4'd2)) begin failures++; $display("FAIL b2b_ready n=%0d got=%b", n, dma_if.dma_ready); end
            tick();
            checks++; if (dac_data !== exp_data) begin failures++; $display("FAIL b2b_data n=%0d sel=%0d got=%h exp=%h", n, m_sel, dac_data, exp_data); end
            checks++; if (dac_enable !== exp_en) begin failures++; $display("FAIL b2b_en n=%0d got=%b exp=%b", n, dac_enable, exp_en); end
            checks++; if (dac_sel_active !== m_sel) begin failures++; $display("FAIL b2b_sel n=%0d got=%h exp=%h", n, dac_sel_active, m_sel); end
            checks++; if (dac_underflow_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL b2b_cnt n=%0d got=%0d exp=%0d", n, dac_underflow_cnt, m_cnt); end
        end
        pat_wr_en = 1'b0;
        dac_data_sync = 1'b0;
        underflow_clr = 1'b0;
    endtask

    task automatic test_saturation();
        int unsigned run;
`ifdef AD_TPL_DAC_UNDERFLOW_CNT_EN
        run = 70000;
`else
        run = 8;
`endif
        dac_data_sel = 4'd2;
        dac_data_sync = 1'b1;
        dma_if.dma_valid = 1'b0;
        underflow_clr = 1'b0;
        tick();
        dac_data_sync = 1'b0;
        for (int unsigned n = 0; n < run && m_cnt < 65535; n++) tick();
        tick(); tick();
        checks++; if (dac_underflow_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL sat_cnt got=%h exp=%h", dac_underflow_cnt, 16'(m_cnt)); end
`ifdef AD_TPL_DAC_UNDERFLOW_CNT_EN
        checks++; if (dac_underflow_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_top got=%h exp=ffff", dac_underflow_cnt); end
`endif
        underflow_clr = 1'b1;
        #1;
        checks++; if (dac_underflow !== 1'b1) begin failures++; $display("FAIL sat_ufl got=%b exp=1", dac_underflow); end
        tick();
        underflow_clr = 1'b0;
        checks++; if (dac_underflow_cnt !== 16'd0) begin failures++; $display("FAIL sat_clr got=%h exp=0", dac_underflow_cnt); end
        tick();
        checks++; if (dac_underflow_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL sat_after got=%h exp=%h", dac_underflow_cnt, 16'(m_cnt)); end
    endtask

    task automatic test_reset_mid();
        dac_data_sel = 4'd2;
        dac_data_sync = 1'b1;
        tick();
        dac_data_sync = 1'b0;
        for (int n = 0; n < 6; n++) begin
            dma_if.dma_valid = $urandom_range(0, 1);
            dma_if.dma_data = {$urandom, $urandom};
            dac_underflow_hold = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        checks++; if (dac_data !== '0) begin failures++; $display("FAIL mid_data got=%h exp=0", dac_data); end
        checks++; if (dac_enable !== 1'b0) begin failures++; $display("FAIL mid_en got=%b exp=0", dac_enable); end
        checks++; if (dac_sel_active !== 4'd3) begin failures++; $display("FAIL mid_sel got=%h exp=3", dac_sel_active); end
        checks++; if (dma_if.dma_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", dma_if.dma_ready); end
        checks++; if (dac_underflow !== 1'b0) begin failures++; $display("FAIL mid_ufl got=%b exp=0", dac_underflow); end
        checks++; if (dac_underflow_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%h exp=0", dac_underflow_cnt); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        dma_if.dma_data = '0;
        dma_if.dma_valid = 1'b0;
        test_reset();
        test_pattern();
        test_ramp();
        test_dma_underflow();
        test_sync_switch();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
